// File: rtl/barrel_fetch.sv
// barrel_fetch: fetch stage of an N-thread barrel processor with a per-thread PC file and F/D register.
// Define BARREL_THREAD_MASK_EN to add thread_en_i, which idles individual threads.
module barrel_fetch #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       BITS_THREADS  = 3,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_f_i,
  input  logic                     flush_d_i,
  input  logic                     redirect_i,
  input  logic [BITS_THREADS-1:0]  redirect_tid_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
`ifdef BARREL_THREAD_MASK_EN
  input  logic [(1<<BITS_THREADS)-1:0] thread_en_i,
`endif
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
  output logic [DATA_WIDTH-1:0]    instr_d_o,
  output logic [ADDRESS_WIDTH-1:0] pc_d_o,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d_o,
  output logic [BITS_THREADS-1:0]  tid_d_o,
  output logic                     valid_d_o
);

  localparam int                       N       = 1 << BITS_THREADS;
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

  logic [ADDRESS_WIDTH-1:0] pc_file_q [N];
  logic [ADDRESS_WIDTH-1:0] pc_file_d [N];
  logic [BITS_THREADS-1:0]  tid_f_q, tid_f_d;

  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [BITS_THREADS-1:0]  tid_q, tid_d;
  logic                     valid_q, valid_d;

  logic [ADDRESS_WIDTH-1:0] cur_pc;
  logic [ADDRESS_WIDTH-1:0] cur_pc_plus4;
  logic                     slot_en;
  logic                     redirect_hit;

`ifdef BARREL_THREAD_MASK_EN
  assign slot_en = thread_en_i[tid_f_q];
`else
  assign slot_en = 1'b1;
`endif

  assign cur_pc       = pc_file_q[tid_f_q];
  assign cur_pc_plus4 = cur_pc + PC_STEP;
  // A redirect aimed at the thread being fetched right now kills this slot.
  assign redirect_hit = redirect_i && (redirect_tid_i == tid_f_q);
  assign imem_addr_o  = cur_pc;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    pc_file_d  = pc_file_q;
    tid_f_d    = tid_f_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    tid_d      = tid_q;
    valid_d    = valid_q;

    if (!stall_f_i) begin
      tid_f_d = tid_f_q + BITS_THREADS'(1);
      if (slot_en) pc_file_d[tid_f_q] = cur_pc_plus4;
    end
    // Written after the +4 update so a redirect always wins, stalled or not.
    if (redirect_i) pc_file_d[redirect_tid_i] = redirect_pc_i;

    if (flush_d_i) begin
      instr_d    = '0;
      pc_d       = '0;
      pc_plus4_d = '0;
      tid_d      = '0;
      valid_d    = 1'b0;
    end else if (!stall_f_i) begin
      instr_d    = imem_rdata_i;
      pc_d       = cur_pc;
      pc_plus4_d = cur_pc_plus4;
      tid_d      = tid_f_q;
      valid_d    = slot_en && !redirect_hit;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the PC file is small control state that must restart at RESET_PC, so it is reset
      // entry by entry; bulk data memories would normally be left unreset.
      for (int i = 0; i < N; i++) pc_file_q[i] <= RESET_PC;
      tid_f_q    <= '0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      tid_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_file_q  <= pc_file_d;
      tid_f_q    <= tid_f_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      tid_q      <= tid_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_d_o    = instr_q;
  assign pc_d_o       = pc_q;
  assign pc_plus4_d_o = pc_plus4_q;
  assign tid_d_o      = tid_q;
  assign valid_d_o    = valid_q;

endmodule

// File: tb/tb_barrel_fetch.sv
// tb_barrel_fetch: directed stimulus for barrel_fetch, checked every cycle against a thread-level
// reference model, plus literal expectations for the key scenarios.
module tb_barrel_fetch;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BT = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          stall, flush, redirect;
  logic [BT-1:0] rtid;
  logic [AW-1:0] rpc;
  logic [N-1:0]  thread_en = '1;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic [DW-1:0] instr_d;
  logic [AW-1:0] pc_d, pc4_d;
  logic [BT-1:0] tid_d;
  logic          valid_d;

  int n_checks = 0;
  int n_fail   = 0;

  barrel_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_f_i      (stall),
    .flush_d_i      (flush),
    .redirect_i     (redirect),
    .redirect_tid_i (rtid),
    .redirect_pc_i  (rpc),
`ifdef BARREL_THREAD_MASK_EN
    .thread_en_i    (thread_en),
`endif
    .imem_addr_o    (imem_addr),
    .imem_rdata_i   (imem_rdata),
    .instr_d_o      (instr_d),
    .pc_d_o         (pc_d),
    .pc_plus4_d_o   (pc4_d),
    .tid_d_o        (tid_d),
    .valid_d_o      (valid_d)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word is a tag derived from its address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one PC per thread, a slot counter, and the expected decode-side word.
  logic [AW-1:0] m_pc [N];
  int            m_tid;
  logic [DW-1:0] e_instr;
  logic [AW-1:0] e_pc, e_pc4;
  int            e_tid;
  logic          e_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_pc[i] <= '0;
      m_tid   <= 0;
      e_instr <= '0;
      e_pc    <= '0;
      e_pc4   <= '0;
      e_tid   <= 0;
      e_valid <= 1'b0;
    end else begin
      if (!stall) begin
        m_tid <= (m_tid + 1) % N;
        if (thread_en[m_tid]) m_pc[m_tid] <= m_pc[m_tid] + 32'd4;
      end
      if (redirect) m_pc[rtid] <= rpc;
      if (flush) begin
        e_instr <= '0;
        e_pc    <= '0;
        e_pc4   <= '0;
        e_tid   <= 0;
        e_valid <= 1'b0;
      end else if (!stall) begin
        e_instr <= mem_word(m_pc[m_tid]);
        e_pc    <= m_pc[m_tid];
        e_pc4   <= m_pc[m_tid] + 32'd4;
        e_tid   <= m_tid;
        e_valid <= thread_en[m_tid] && !(redirect && int'(rtid) == m_tid);
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_addr",  64'(imem_addr), 64'(m_pc[m_tid]));
    check("cmp_instr", 64'(instr_d),   64'(e_instr));
    check("cmp_pc",    64'(pc_d),      64'(e_pc));
    check("cmp_pc4",   64'(pc4_d),     64'(e_pc4));
    check("cmp_tid",   64'(tid_d),     64'(e_tid));
    check("cmp_valid", 64'(valid_d),   64'(e_valid));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until a slot of thread t reaches decode; an expired bound is a failed check.
  task automatic step_until_tid(input int t);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * N && !found; i++) begin
      step();
      found = (int'(tid_d) == t);
    end
    check("reach_tid", 64'(found), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    stall = 0; flush = 0; redirect = 0; rtid = '0; rpc = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", 64'(valid_d), 64'(0));
    check("rst_pc",    64'(pc_d),    64'(0));
    check("rst_tid",   64'(tid_d),   64'(0));
    check("rst_addr",  64'(imem_addr), 64'(0));
    repeat (2) step();
    rst_n = 1'b1;

    // Round robin from reset: tids 0..7,0,1; PCs 0 then 4 on the second visit.
    for (int i = 0; i < 10; i++) begin
      step();
      check("rr_tid",   64'(tid_d),   64'(i % 8));
      check("rr_pc",    64'(pc_d),    64'((i < 8) ? 0 : 4));
      check("rr_valid", 64'(valid_d), 64'(1));
    end

    // Redirect thread 3 while thread 5 is fetching.
    repeat (3) step();
    check("pre_redir_tid", 64'(tid_d), 64'(4));
    redirect = 1; rtid = 3'd3; rpc = 32'h100;
    step();
    redirect = 0;
    step_until_tid(3);
    check("redir3_pc",    64'(pc_d),    64'(32'h100));
    check("redir3_pc4",   64'(pc4_d),   64'(32'h104));
    check("redir3_valid", 64'(valid_d), 64'(1));

    // Redirect thread 2 in its own fetch slot: that slot is killed.
    for (int i = 0; i < N && m_tid != 2; i++) step();
    redirect = 1; rtid = 3'd2; rpc = 32'h200;
    step();
    redirect = 0;
    check("kill_tid",   64'(tid_d),   64'(2));
    check("kill_valid", 64'(valid_d), 64'(0));
    step_until_tid(2);
    check("redir2_pc",    64'(pc_d),    64'(32'h200));
    check("redir2_valid", 64'(valid_d), 64'(1));

    // Three stalled cycles with a redirect of thread 6 landing in the first.
    stall = 1; redirect = 1; rtid = 3'd6; rpc = 32'h600;
    for (int i = 0; i < 3; i++) begin
      step();
      redirect = 0;
      check("stall_tid",   64'(tid_d),   64'(2));
      check("stall_pc",    64'(pc_d),    64'(32'h200));
      check("stall_valid", 64'(valid_d), 64'(1));
    end
    stall = 0;
    step();
    check("unstall_tid", 64'(tid_d), 64'(3));
    step_until_tid(6);
    check("redir6_pc", 64'(pc_d), 64'(32'h600));

    // Flush with stall clears F/D and holds the slot pointer.
    stall = 1; flush = 1;
    step();
    check("flush_instr", 64'(instr_d), 64'(0));
    check("flush_pc",    64'(pc_d),    64'(0));
    check("flush_pc4",   64'(pc4_d),   64'(0));
    check("flush_tid",   64'(tid_d),   64'(0));
    check("flush_valid", 64'(valid_d), 64'(0));
    stall = 0; flush = 0;
    step();
    check("post_flush_tid", 64'(tid_d), 64'(7));
    // Flush alone still advances the slot pointer.
    flush = 1;
    step();
    check("flush_only_valid", 64'(valid_d), 64'(0));
    flush = 0;
    step();
    check("post_flush_only_tid", 64'(tid_d), 64'(1));

    // PC+4 wraps modulo 2^ADDRESS_WIDTH.
    redirect = 1; rtid = 3'd5; rpc = 32'hFFFF_FFFC;
    step();
    redirect = 0;
    step_until_tid(5);
    check("wrap_pc",  64'(pc_d),  64'(32'hFFFF_FFFC));
    check("wrap_pc4", 64'(pc4_d), 64'(0));

    // Reset mid-stream with a redirect pending discards the redirect.
    redirect = 1; rtid = 3'd0; rpc = 32'h300;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(valid_d),   64'(0));
    check("midrst_addr",  64'(imem_addr), 64'(0));
    redirect = 0;
    step();
    rst_n = 1'b1;
    step();
    check("rel_tid",   64'(tid_d),   64'(0));
    check("rel_pc",    64'(pc_d),    64'(0));
    check("rel_valid", 64'(valid_d), 64'(1));
    step_until_tid(0);
    check("rel_pc_round2", 64'(pc_d), 64'(4));

`ifdef BARREL_THREAD_MASK_EN
    // Thread 0 masked off: its slots are empty and its PC never moves.
    rst_n = 1'b0;
    thread_en = 8'b1111_1110;
    step();
    rst_n = 1'b1;
    step();
    check("mask_tid",   64'(tid_d),   64'(0));
    check("mask_valid", 64'(valid_d), 64'(0));
    step();
    check("mask_next_valid", 64'(valid_d), 64'(1));
    step_until_tid(0);
    check("mask_pc",    64'(pc_d),    64'(0));
    check("mask_valid2", 64'(valid_d), 64'(0));
    thread_en = '1;
    step();
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
